// File: rtl/tsp_pkg.sv
// Shared defaults and FSM state encoding for the tile-slice memory responder.
package tsp_pkg;

  localparam int unsigned DefInstrMemAddrWidth = 10;
  localparam int unsigned DefNumVectors        = 5;
  localparam int unsigned DefMinVecLength      = 16;
  localparam int unsigned DefNumTilesPerSlice  = 20;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StWrite = 2'd2
  } state_e;

endpackage

// File: rtl/mem_slice_array.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
module mem_slice_array #(
  parameter int unsigned AddrWidth = 10,
  parameter int unsigned DataWidth = 320
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] waddr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic                 re_i,
  input  logic [AddrWidth-1:0] raddr_i,
  output logic [DataWidth-1:0] rdata_o
);

  localparam int unsigned Depth = 2 ** AddrWidth;

  logic [DataWidth-1:0] mem_q [Depth];
  logic [DataWidth-1:0] rdata_q;

  // Contents are deliberately never reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_slice_responder.sv
// Burst read/write responder in front of a vector-wide RAM; one command at a time,
// commands only in idle, wrapping burst addresses.
module mem_slice_responder
  import tsp_pkg::*;
#(
  parameter int unsigned INSTR_MEM_ADDR_WIDTH = DefInstrMemAddrWidth,
  parameter int unsigned NUM_VECTORS          = DefNumVectors,
  parameter int unsigned MIN_VEC_LENGTH       = DefMinVecLength,
  parameter int unsigned NUM_TILES_PER_SLICE  = DefNumTilesPerSlice
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            mem_read_enable,
  input  logic                            mem_write_enable,
  input  logic [INSTR_MEM_ADDR_WIDTH-1:0] mem_address,
  input  logic [NUM_VECTORS-1:0]          vector_length,
  input  logic [MIN_VEC_LENGTH-1:0]       write_data [0:NUM_TILES_PER_SLICE-1],
  output logic [MIN_VEC_LENGTH-1:0]       rd_data    [0:NUM_TILES_PER_SLICE-1],
  output logic                            rd_valid,
  output logic                            rd_last,
  output logic                            busy,
  output logic                            cmd_error
);

  localparam int unsigned DataWidth = MIN_VEC_LENGTH * NUM_TILES_PER_SLICE;
  localparam logic [INSTR_MEM_ADDR_WIDTH-1:0] AddrOne = 1;
  localparam logic [NUM_VECTORS-1:0]          LenOne  = 1;

  state_e                          state_q;
  logic [INSTR_MEM_ADDR_WIDTH-1:0] addr_q;
  logic [NUM_VECTORS-1:0]          len_q;
  logic [NUM_VECTORS-1:0]          cnt_q;
  logic                            rd_valid_q;
  logic                            rd_last_q;
  logic                            busy_q;
  logic                            cmd_error_q;

  logic                            idle;
  logic                            len_nz;
  logic                            any_cmd;
  logic                            both_cmd;
  logic                            accept_rd;
  logic                            accept_wr;
  logic                            last_beat;

  logic                            ram_we;
  logic [INSTR_MEM_ADDR_WIDTH-1:0] ram_waddr;
  logic [DataWidth-1:0]            ram_wdata;
  logic                            ram_re;
  logic [DataWidth-1:0]            ram_rdata;

  assign idle      = (state_q == StIdle);
  assign len_nz    = (vector_length != '0);
  assign any_cmd   = mem_read_enable | mem_write_enable;
  assign both_cmd  = mem_read_enable & mem_write_enable;
  assign accept_rd = idle & mem_read_enable & ~mem_write_enable & len_nz;
  assign accept_wr = idle & mem_write_enable & ~mem_read_enable & len_nz;
  assign last_beat = (cnt_q == (len_q - LenOne));

  // Beat 0 of a write is committed on the accepting edge, straight from the port address.
  always_comb begin
    ram_we    = ~rst & (accept_wr | (state_q == StWrite));
    ram_waddr = (state_q == StWrite) ? addr_q : mem_address;
    ram_re    = (state_q == StRead);
    ram_wdata = '0;
    for (int t = 0; t < int'(NUM_TILES_PER_SLICE); t++) begin
      ram_wdata[t*MIN_VEC_LENGTH +: MIN_VEC_LENGTH] = write_data[t];
    end
  end

  mem_slice_array #(
    .AddrWidth(INSTR_MEM_ADDR_WIDTH),
    .DataWidth(DataWidth)
  ) u_array (
    .clk_i  (clk),
    .we_i   (ram_we),
    .waddr_i(ram_waddr),
    .wdata_i(ram_wdata),
    .re_i   (ram_re),
    .raddr_i(addr_q),
    .rdata_o(ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      busy_q      <= 1'b0;
      cmd_error_q <= 1'b0;
    end else begin
      busy_q      <= (state_q != StIdle);
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      cmd_error_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (both_cmd) begin
            cmd_error_q <= 1'b1;
          end else if (accept_rd) begin
            state_q <= StRead;
            addr_q  <= mem_address;
            len_q   <= vector_length;
            cnt_q   <= '0;
          end else if (accept_wr) begin
            addr_q <= mem_address + AddrOne;
            len_q  <= vector_length;
            cnt_q  <= LenOne;
            if (vector_length != LenOne) begin
              state_q <= StWrite;
            end
          end
        end
        StRead: begin
          // The RAM registers addr_q on this edge, so the beat flags go out with it.
          cmd_error_q <= any_cmd;
          rd_valid_q  <= 1'b1;
          rd_last_q   <= last_beat;
          addr_q      <= addr_q + AddrOne;
          cnt_q       <= cnt_q + LenOne;
          if (last_beat) begin
            state_q <= StIdle;
          end
        end
        StWrite: begin
          cmd_error_q <= any_cmd;
          addr_q      <= addr_q + AddrOne;
          cnt_q       <= cnt_q + LenOne;
          if (last_beat) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    for (int t = 0; t < int'(NUM_TILES_PER_SLICE); t++) begin
      rd_data[t] = rd_valid_q ? ram_rdata[t*MIN_VEC_LENGTH +: MIN_VEC_LENGTH] : '0;
    end
  end

  assign rd_valid  = rd_valid_q;
  assign rd_last   = rd_last_q;
  assign busy      = busy_q;
  assign cmd_error = cmd_error_q;

endmodule

// File: tb/tb_mem_slice_responder.sv
// Directed bench for mem_slice_responder: bursts, wrap, dropped commands, reset abort.
module tb_mem_slice_responder;

  localparam int unsigned AW = 10;
  localparam int unsigned LW = 5;
  localparam int unsigned W  = 16;
  localparam int unsigned N  = 20;
  localparam int unsigned DW = W * N;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rd_en = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [LW-1:0] len = '0;
  logic [W-1:0]  wdata   [0:N-1];
  logic [W-1:0]  rd_data [0:N-1];
  logic          rd_valid;
  logic          rd_last;
  logic          busy;
  logic          cmd_error;
  logic [DW-1:0] rd_flat;
  logic [DW-1:0] exp_q [$];
  int            n_vec = 0;
  int            n_err = 0;

  mem_slice_responder #(
    .INSTR_MEM_ADDR_WIDTH(AW),
    .NUM_VECTORS         (LW),
    .MIN_VEC_LENGTH      (W),
    .NUM_TILES_PER_SLICE (N)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_read_enable (rd_en),
    .mem_write_enable(wr_en),
    .mem_address     (addr),
    .vector_length   (len),
    .write_data      (wdata),
    .rd_data         (rd_data),
    .rd_valid        (rd_valid),
    .rd_last         (rd_last),
    .busy            (busy),
    .cmd_error       (cmd_error)
  );

  always #5 clk = ~clk;

  always_comb begin
    rd_flat = '0;
    for (int t = 0; t < int'(N); t++) rd_flat[t*W +: W] = rd_data[t];
  end

  function automatic logic [DW-1:0] fill(input logic [W-1:0] v);
    logic [DW-1:0] r;
    for (int t = 0; t < int'(N); t++) r[t*W +: W] = v;
    return r;
  endfunction

  // Tile-distinct pattern so a tile swap or beat reorder is visible.
  function automatic logic [DW-1:0] pat(input int beat);
    logic [DW-1:0] r;
    for (int t = 0; t < int'(N); t++) r[t*W +: W] = W'(32'hC000 + beat * 256 + t);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkd(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_wdata(input logic [DW-1:0] f);
    for (int t = 0; t < int'(N); t++) wdata[t] = f[t*W +: W];
  endtask

  task automatic write_burst(input string tag, input logic [AW-1:0] a, input int l);
    wr_en = 1'b1;
    addr  = a;
    len   = LW'(l);
    drive_wdata(exp_q[0]);
    tick();
    wr_en = 1'b0;
    for (int i = 1; i < l; i++) begin
      if (i == 2) chk1({tag, "_busy_mid"}, busy, 1'b1);
      drive_wdata(exp_q[i]);
      tick();
    end
    tick();
    chk1({tag, "_busy_done"}, busy, 1'b0);
  endtask

  task automatic read_check(input string tag, input logic [AW-1:0] a, input int l);
    rd_en = 1'b1;
    addr  = a;
    len   = LW'(l);
    tick();
    rd_en = 1'b0;
    chk1({tag, "_lat_valid"}, rd_valid, 1'b0);
    for (int i = 0; i < l; i++) begin
      tick();
      chk1($sformatf("%s_valid%0d", tag, i), rd_valid, 1'b1);
      chkd($sformatf("%s_data%0d", tag, i), rd_flat, exp_q[i]);
      chk1($sformatf("%s_last%0d", tag, i), rd_last, (i == l - 1));
      chk1($sformatf("%s_busy%0d", tag, i), busy, 1'b1);
    end
    tick();
    chk1({tag, "_end_valid"}, rd_valid, 1'b0);
    chk1({tag, "_end_busy"}, busy, 1'b0);
    chkd({tag, "_end_zero"}, rd_flat, '0);
  endtask

  initial begin
    drive_wdata('0);
    #2;
    chk1("rst_valid", rd_valid, 1'b0);
    chk1("rst_last", rd_last, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_err", cmd_error, 1'b0);
    chkd("rst_data", rd_flat, '0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // Basic write then read-back.
    exp_q = '{fill(16'h1111), fill(16'h2222), fill(16'h3333)};
    write_burst("a_wr", 10'h010, 3);
    read_check("a_rd", 10'h010, 3);

    // Wrapping write and read across the top of the address space.
    exp_q = '{pat(0), pat(1), pat(2), pat(3)};
    write_burst("b_wr", 10'h3FE, 4);
    read_check("b_rd", 10'h3FE, 4);
    exp_q = '{pat(2)};
    read_check("b_rd0", 10'h000, 1);

    // Both strobes together in idle: dropped, memory untouched.
    rd_en = 1'b1;
    wr_en = 1'b1;
    addr  = 10'h010;
    len   = 5'd1;
    drive_wdata(fill(16'hDEAD));
    tick();
    rd_en = 1'b0;
    wr_en = 1'b0;
    chk1("c_err", cmd_error, 1'b1);
    chk1("c_busy", busy, 1'b0);
    chk1("c_valid", rd_valid, 1'b0);
    tick();
    chk1("c_err_clr", cmd_error, 1'b0);
    chk1("c_busy2", busy, 1'b0);
    exp_q = '{fill(16'h1111)};
    read_check("c_rd", 10'h010, 1);

    // Read strobe during an L=5 write is dropped; the write still completes.
    exp_q = '{fill(16'h5000), fill(16'h5001), fill(16'h5002), fill(16'h5003), fill(16'h5004)};
    wr_en = 1'b1;
    addr  = 10'h100;
    len   = 5'd5;
    drive_wdata(exp_q[0]);
    tick();
    wr_en = 1'b0;
    drive_wdata(exp_q[1]);
    tick();
    drive_wdata(exp_q[2]);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk1("d_err", cmd_error, 1'b1);
    chk1("d_valid", rd_valid, 1'b0);
    chk1("d_busy", busy, 1'b1);
    drive_wdata(exp_q[3]);
    tick();
    chk1("d_err_clr", cmd_error, 1'b0);
    drive_wdata(exp_q[4]);
    tick();
    chk1("d_valid2", rd_valid, 1'b0);
    tick();
    chk1("d_busy_done", busy, 1'b0);
    read_check("d_rd", 10'h100, 5);

    // Reset during the second beat of an L=8 read.
    rd_en = 1'b1;
    addr  = 10'h100;
    len   = 5'd8;
    tick();
    rd_en = 1'b0;
    tick();
    chkd("e_beat0", rd_flat, fill(16'h5000));
    tick();
    chk1("e_beat1_valid", rd_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk1("e_rst_valid", rd_valid, 1'b0);
    chk1("e_rst_last", rd_last, 1'b0);
    chk1("e_rst_busy", busy, 1'b0);
    chkd("e_rst_data", rd_flat, '0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    tick();
    chk1("e_post_valid", rd_valid, 1'b0);
    chk1("e_post_busy", busy, 1'b0);
    exp_q = '{fill(16'h5001), fill(16'h5002)};
    read_check("e_rd", 10'h101, 2);

    // Zero-length read is a silent no-op.
    rd_en = 1'b1;
    addr  = 10'h010;
    len   = 5'd0;
    tick();
    rd_en = 1'b0;
    chk1("f_valid", rd_valid, 1'b0);
    chk1("f_busy", busy, 1'b0);
    chk1("f_err", cmd_error, 1'b0);
    tick();
    chk1("f_valid2", rd_valid, 1'b0);
    chk1("f_busy2", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
